// File: rtl/mem_stage_mc_pkg.sv
// Shared types and lane helpers for the multi-cycle MEM stage.
package mem_pkg;

  localparam int MEM_XLEN = 32;

  // Access width, funct3 encoding
  typedef enum logic [2:0] {
    RW_B  = 3'b000,
    RW_H  = 3'b001,
    RW_W  = 3'b010,
    RW_BU = 3'b100,
    RW_HU = 3'b101
  } rw_type_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_MISALIGN = 2'd1,
    FLT_BUSERR   = 2'd2,
    FLT_TIMEOUT  = 2'd3
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic       MemRW;
    logic [2:0] RWType;
  } mem_ctrl_t;

  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
  } wb_ctrl_t;

  typedef struct packed {
    logic                Jump;
    logic                Branch;
    logic                InverseBranch;
    logic                zero;
    logic [MEM_XLEN-1:0] pc_incr;
    logic [MEM_XLEN-1:0] pc_offset;
    logic [MEM_XLEN-1:0] immediate;
    logic [MEM_XLEN-1:0] alu_result;
    logic [MEM_XLEN-1:0] rs2_data;
    logic [4:0]          rd_addr;
    mem_ctrl_t           mem_ctrl;
    wb_ctrl_t            wb_ctrl;
  } ex_mem_flow_t;

  typedef struct packed {
    logic [MEM_XLEN-1:0] pc_write;
    logic [MEM_XLEN-1:0] immediate;
    logic [MEM_XLEN-1:0] alu_result;
    logic [MEM_XLEN-1:0] data_in;
    logic [4:0]          rd_addr;
    wb_ctrl_t            wb_ctrl;
  } mem_wb_flow_t;

  // Byte lanes touched by an access of width rw at byte offset off
  function automatic logic [3:0] be_gen(input logic [2:0] rw, input logic [1:0] off);
    case (rw)
      RW_B, RW_BU: return 4'b0001 << off;
      RW_H, RW_HU: return 4'b0011 << off;
      default:     return 4'b1111;
    endcase
  endfunction

  // Halfwords must sit on even bytes, words on word boundaries
  function automatic logic is_misaligned(input logic [2:0] rw, input logic [1:0] off);
    case (rw)
      RW_H, RW_HU: return off[0];
      RW_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Replicate the low bytes of store data into every lane so be picks the right one
  function automatic logic [MEM_XLEN-1:0] wdata_gen(input logic [2:0] rw,
                                                    input logic [MEM_XLEN-1:0] rs2);
    case (rw)
      RW_B, RW_BU: return {4{rs2[7:0]}};
      RW_H, RW_HU: return {2{rs2[15:0]}};
      default:     return rs2;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_mc_load_align.sv
// Load alignment: move the addressed byte/halfword to bit 0 and extend it.
module load_align
  import mem_pkg::*;
(
  input  logic [MEM_XLEN-1:0] rdata,
  input  logic [1:0]          addr_lo,
  input  logic [2:0]          rw_type,
  output logic [MEM_XLEN-1:0] data
);

  logic [15:0] lane;

  // Select the addressed lane, then sign- or zero-extend by access type
  always_comb begin
    lane = 16'(rdata >> {addr_lo, 3'b000});
    case (rw_type)
      RW_B:    data = {{24{lane[7]}}, lane[7:0]};
      RW_H:    data = {{16{lane[15]}}, lane[15:0]};
      RW_BU:   data = {24'd0, lane[7:0]};
      RW_HU:   data = {16'd0, lane[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_mc.sv
// Multi-cycle MEM stage: issues loads/stores on a req/ack bus, stalls upstream
// while the access is outstanding and presents the aligned result to MEM/WB.
//
// Handshake: an instruction on inflow is consumed in the cycle where
// in_valid & in_ready are both high; upstream holds inflow stable otherwise.
// out_valid marks a live outflow/fault for exactly that one cycle. On the
// memory side dm_req stays high with constant dm_we/addr/be/wdata until the
// cycle dm_ack is sampled high (or the timeout fires); dm_rdata/dm_err are
// only looked at together with dm_ack.
module mem_stage_mc
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  ex_mem_flow_t      inflow,
  input  logic              in_valid,
  output logic              in_ready,
  output mem_wb_flow_t      outflow,
  output logic              out_valid,
  output logic [1:0]        fault,
  output logic              PCSrc,
  output logic [XLEN-1:0]   pc_offset,
  output logic              dm_req,
  output logic              dm_we,
  output logic [XLEN-1:0]   dm_addr,
  output logic [3:0]        dm_be,
  output logic [XLEN-1:0]   dm_wdata,
  input  logic [XLEN-1:0]   dm_rdata,
  input  logic              dm_ack,
  input  logic              dm_err
);

  // A zero-width counter is not legal, keep at least one bit
  localparam int          CW     = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [31:0] TO_LIM = TIMEOUT;

  mem_state_e       state;
  logic [CW-1:0]    cnt;
  logic [XLEN-1:0]  cap_data;
  fault_e           cap_fault;

  // Request fields frozen for the whole WAIT phase
  logic             h_we;
  logic [XLEN-1:0]  h_addr;
  logic [3:0]       h_be;
  logic [XLEN-1:0]  h_wdata;
  logic [1:0]       h_off;
  logic [2:0]       h_rw;

  logic             is_load;
  logic             is_store;
  logic             is_mem;
  logic             misal;
  logic [1:0]       off_c;
  logic [XLEN-1:0]  addr_c;
  logic [3:0]       be_c;
  logic [XLEN-1:0]  wdata_c;
  logic             start_acc;
  logic [31:0]      cnt_inc;
  logic             timeout_hit;
  logic [XLEN-1:0]  ld_data;
  logic [XLEN-1:0]  data_sel;
  fault_e           flt;

  // Decode the incoming instruction and build the request it would issue
  always_comb begin
    is_load   = inflow.wb_ctrl.MemtoReg;
    is_store  = inflow.mem_ctrl.MemRW;
    is_mem    = is_load | is_store;
    off_c     = inflow.alu_result[1:0];
    misal     = is_misaligned(inflow.mem_ctrl.RWType, off_c);
    addr_c    = {inflow.alu_result[XLEN-1:2], 2'b00};
    be_c      = be_gen(inflow.mem_ctrl.RWType, off_c);
    wdata_c   = wdata_gen(inflow.mem_ctrl.RWType, inflow.rs2_data);
    start_acc = in_valid & is_mem & ~misal;
  end

  // The request cycle in IDLE counts as the first bus cycle, so the counter
  // enters WAIT at 1 and TIMEOUT counts every cycle dm_req was high
  always_comb begin
    cnt_inc     = 32'(cnt) + 32'd1;
    timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_LIM);
  end

  load_align u_load_align (
    .rdata   (dm_rdata),
    .addr_lo (h_off),
    .rw_type (h_rw),
    .data    (ld_data)
  );

  // Stage controller: IDLE issues, WAIT holds the request, RESP retires it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_data  <= '0;
      cap_fault <= FLT_NONE;
      h_we      <= 1'b0;
      h_addr    <= '0;
      h_be      <= '0;
      h_wdata   <= '0;
      h_off     <= '0;
      h_rw      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            state   <= ST_WAIT;
            cnt     <= (TIMEOUT != 0) ? CW'(1) : '0;
            h_we    <= is_store;
            h_addr  <= addr_c;
            h_be    <= be_c;
            h_wdata <= wdata_c;
            h_off   <= off_c;
            h_rw    <= inflow.mem_ctrl.RWType;
          end
        end
        ST_WAIT: begin
          if (dm_ack) begin
            cap_data  <= ld_data;
            cap_fault <= dm_err ? FLT_BUSERR : FLT_NONE;
            state     <= ST_RESP;
          end else if (timeout_hit) begin
            cap_data  <= '0;
            cap_fault <= FLT_TIMEOUT;
            state     <= ST_RESP;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt_inc[CW-1:0];
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake, bus and fault outputs; reset forces the quiet values at once
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    flt       = FLT_NONE;
    data_sel  = '0;
    dm_req    = 1'b0;
    dm_we     = h_we;
    dm_addr   = h_addr;
    dm_be     = h_be;
    dm_wdata  = h_wdata;
    case (state)
      ST_IDLE: begin
        dm_we    = is_store & ~misal;
        dm_addr  = addr_c;
        dm_be    = be_c;
        dm_wdata = wdata_c;
        if (in_valid) begin
          if (!is_mem) begin
            out_valid = 1'b1;
          end else if (misal) begin
            out_valid = 1'b1;
            flt       = FLT_MISALIGN;
          end else begin
            dm_req   = 1'b1;
            in_ready = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        dm_req   = 1'b1;
        in_ready = 1'b0;
      end
      ST_RESP: begin
        out_valid = 1'b1;
        flt       = cap_fault;
        data_sel  = cap_data;
      end
      default: ;
    endcase
    if (!rst_n) begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      flt       = FLT_NONE;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
    end
  end

  // MEM/WB payload and redirect toward IF
  always_comb begin
    outflow.pc_write   = inflow.Jump ? inflow.pc_incr : inflow.pc_offset;
    outflow.immediate  = inflow.immediate;
    outflow.alu_result = inflow.alu_result;
    outflow.data_in    = data_sel;
    outflow.rd_addr    = inflow.rd_addr;
    outflow.wb_ctrl    = inflow.wb_ctrl;
    if (flt != FLT_NONE) outflow.wb_ctrl.RegWrite = 1'b0;
    fault     = flt;
    pc_offset = inflow.pc_offset;
    PCSrc     = rst_n & in_valid & in_ready &
                (inflow.Jump | (inflow.Branch & (inflow.InverseBranch ^ inflow.zero)));
  end

endmodule

// File: tb/tb_mem_stage_mc.sv
// Bench for mem_stage_mc: directed cases followed by random traffic against a
// memory responder with programmable latency and a scoreboard.
module tb_mem_stage_mc;
  import mem_pkg::*;

  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  ex_mem_flow_t inflow = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  mem_wb_flow_t outflow;
  logic         out_valid;
  logic [1:0]   fault;
  logic         PCSrc;
  logic [31:0]  pc_offset;
  logic         dm_req, dm_we;
  logic [31:0]  dm_addr, dm_wdata;
  logic [3:0]   dm_be;
  logic [31:0]  dm_rdata = '0;
  logic         dm_ack = 1'b0;
  logic         dm_err = 1'b0;

  always #5 clk = ~clk;

  mem_stage_mc #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .inflow(inflow), .in_valid(in_valid),
    .in_ready(in_ready), .outflow(outflow), .out_valid(out_valid),
    .fault(fault), .PCSrc(PCSrc), .pc_offset(pc_offset),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err)
  );

  typedef struct packed {
    logic [31:0] data_in;
    logic        chk_data;
    logic [1:0]  fault;
    logic        reg_write;
    logic [31:0] pc_write;
    logic        pcsrc;
    logic [31:0] pc_offset;
    logic [4:0]  rd_addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Memory responder programming and expected request fields
  int          mem_lat = 1;
  logic [31:0] mem_rdata = '0;
  logic        mem_err = 1'b0;
  int          req_cycles = 0;
  int          req_run = 0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_wdata = '0;

  logic [2:0] rw_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_bytes(input logic [2:0] rw);
    if (rw == 3'b000 || rw == 3'b100) return 1;
    if (rw == 3'b001 || rw == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit is_mem_op(input ex_mem_flow_t f);
    return f.wb_ctrl.MemtoReg || f.mem_ctrl.MemRW;
  endfunction

  function automatic bit is_misal(input ex_mem_flow_t f);
    int off = int'(f.alu_result[1:0]);
    return (off % acc_bytes(f.mem_ctrl.RWType)) != 0;
  endfunction

  // lat = number of WAIT cycles before ack; 0 = memory never answers
  function automatic exp_t model(input ex_mem_flow_t f, input int lat,
                                 input logic [31:0] rdata, input logic err);
    exp_t        e;
    int          nb  = acc_bytes(f.mem_ctrl.RWType);
    int          off = int'(f.alu_result[1:0]);
    bit          sgn = (f.mem_ctrl.RWType == 3'b000) || (f.mem_ctrl.RWType == 3'b001);
    logic [31:0] val, m;
    e.rd_addr   = f.rd_addr;
    e.pc_offset = f.pc_offset;
    e.pc_write  = f.Jump ? f.pc_incr : f.pc_offset;
    e.pcsrc     = f.Jump || (f.Branch && (f.InverseBranch != f.zero));
    e.reg_write = f.wb_ctrl.RegWrite;
    e.data_in   = 32'd0;
    e.chk_data  = 1'b1;
    e.fault     = 2'd0;
    if (is_mem_op(f)) begin
      if (is_misal(f)) begin
        e.fault = 2'd1;
      end else if (lat == 0) begin
        e.fault    = 2'd3;
        e.chk_data = 1'b0;
      end else begin
        e.fault = err ? 2'd2 : 2'd0;
        val = rdata >> (8 * off);
        if (nb < 4) begin
          m   = (32'd1 << (8 * nb)) - 32'd1;
          val = val & m;
          if (sgn && val[8*nb-1]) val = val | ~m;
        end
        e.data_in = val;
      end
      if (e.fault != 2'd0) e.reg_write = 1'b0;
    end
    return e;
  endfunction

  task automatic set_bus_expect(input ex_mem_flow_t f);
    int nb  = acc_bytes(f.mem_ctrl.RWType);
    int off = int'(f.alu_result[1:0]);
    exp_we    = f.mem_ctrl.MemRW;
    exp_addr  = f.alu_result & 32'hFFFF_FFFC;
    exp_be    = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = f.rs2_data[8*(i % nb) +: 8];
  endtask

  // ---------------- memory responder ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (dm_req) begin
        req_run++;
        req_cycles++;
        chk("dm_we",    32'(dm_we),    32'(exp_we));
        chk("dm_addr",  dm_addr,       exp_addr);
        chk("dm_be",    32'(dm_be),    32'(exp_be));
        chk("dm_wdata", dm_wdata,      exp_wdata);
        if (mem_lat != 0 && req_run == mem_lat + 1) begin
          dm_ack   = 1'b1;
          dm_err   = mem_err;
          dm_rdata = mem_rdata;
        end else begin
          dm_ack   = 1'b0;
          dm_err   = 1'b0;
          dm_rdata = $urandom;
        end
      end else begin
        req_run = 0;
        dm_ack  = 1'b0;
        dm_err  = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: actual=out_valid expected=idle (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("fault",     32'(fault),                     32'(e.fault));
          if (e.chk_data) chk("data_in", outflow.data_in,  e.data_in);
          chk("reg_write", 32'(outflow.wb_ctrl.RegWrite),  32'(e.reg_write));
          chk("pc_write",  outflow.pc_write,               e.pc_write);
          chk("pcsrc",     32'(PCSrc),                     32'(e.pcsrc));
          chk("pc_offset", pc_offset,                      e.pc_offset);
          chk("rd_addr",   32'(outflow.rd_addr),           32'(e.rd_addr));
        end
      end else begin
        chk("pcsrc_idle", 32'(PCSrc), 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input ex_mem_flow_t f, input int lat,
                       input logic [31:0] rdata, input logic err);
    int stall = 0;
    bit done  = 0;
    int exp_stall;
    exp_q.push_back(model(f, lat, rdata, err));
    set_bus_expect(f);
    if (is_mem_op(f) && !is_misal(f)) exp_stall = (lat == 0) ? TIMEOUT : lat + 1;
    else exp_stall = 0;
    mem_lat    = lat;
    mem_rdata  = rdata;
    mem_err    = err;
    req_cycles = 0;
    inflow     = f;
    in_valid   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        break;
      end
      stall++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual=no in_ready expected=in_ready within 100 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("stall_cycles", stall, exp_stall);
    chk("req_cycles", req_cycles, exp_stall);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    inflow   = rand_instr($urandom_range(0, 2));
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic ex_mem_flow_t rand_instr(input int kind);
    ex_mem_flow_t f;
    f.pc_incr    = $urandom;
    f.pc_offset  = $urandom;
    f.immediate  = $urandom;
    f.alu_result = $urandom;
    f.rs2_data   = $urandom;
    f.rd_addr    = 5'($urandom);
    f.zero       = 1'($urandom);
    f.InverseBranch = 1'($urandom);
    f.wb_ctrl.RegWrite = 1'($urandom);
    f.mem_ctrl.RWType  = rw_tab[$urandom_range(0, 4)];
    f.Jump = 1'b0;
    f.Branch = 1'b0;
    f.wb_ctrl.MemtoReg = 1'b0;
    f.mem_ctrl.MemRW   = 1'b0;
    case (kind)
      0: begin
        f.Jump   = ($urandom_range(0, 3) == 0);
        f.Branch = 1'($urandom);
      end
      1: begin
        f.wb_ctrl.MemtoReg = 1'b1;
        f.wb_ctrl.RegWrite = 1'b1;
      end
      default: begin
        f.mem_ctrl.MemRW   = 1'b1;
        f.mem_ctrl.RWType  = rw_tab[$urandom_range(0, 2)];
        f.wb_ctrl.RegWrite = 1'b0;
      end
    endcase
    return f;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    ex_mem_flow_t f;
    int lat;

    // clock/reset
    #12;
    chk("rst_dm_req",    32'(dm_req),    32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pcsrc",     32'(PCSrc),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_fault",     32'(fault),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LB at 0x103, ack in third WAIT cycle
    f = rand_instr(1);
    f.mem_ctrl.RWType = RW_B;
    f.alu_result = 32'h0000_0103;
    issue(f, 3, 32'h80FF_1234, 1'b0);

    // SH of 0xABCD at 0x202
    f = rand_instr(2);
    f.mem_ctrl.RWType = RW_H;
    f.alu_result = 32'h0000_0202;
    f.rs2_data   = 32'h0000_ABCD;
    issue(f, 1, 32'h1111_2222, 1'b0);

    // misaligned LW
    f = rand_instr(1);
    f.mem_ctrl.RWType = RW_W;
    f.alu_result = 32'h0000_0101;
    issue(f, 1, 32'h0, 1'b0);

    // LW that is never acknowledged
    f = rand_instr(1);
    f.mem_ctrl.RWType = RW_W;
    f.alu_result = 32'h0000_0300;
    issue(f, 0, 32'h0, 1'b0);

    // LW with bus error
    f = rand_instr(1);
    f.mem_ctrl.RWType = RW_W;
    f.alu_result = 32'h0000_0404;
    issue(f, 2, 32'hDEAD_BEEF, 1'b1);

    // BNE taken
    f = rand_instr(0);
    f.Jump = 1'b0;
    f.Branch = 1'b1;
    f.InverseBranch = 1'b1;
    f.zero = 1'b0;
    f.pc_offset = 32'h0000_0040;
    issue(f, 1, 32'h0, 1'b0);
    idle(2);

    // reset in the middle of an outstanding LW
    f = rand_instr(1);
    f.mem_ctrl.RWType = RW_W;
    f.alu_result = 32'h0000_0040;
    set_bus_expect(f);
    mem_lat  = 0;
    inflow   = f;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_dm_req",   32'(dm_req),   32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LHU at 0x2 after reset
    f = rand_instr(1);
    f.mem_ctrl.RWType = RW_HU;
    f.alu_result = 32'h0000_0002;
    issue(f, 2, 32'hF00D_0000, 1'b0);

    // random traffic
    for (int n = 0; n < 80; n++) begin
      f   = rand_instr($urandom_range(0, 2));
      lat = ($urandom_range(0, 14) == 0) ? 0 : $urandom_range(1, 5);
      issue(f, lat, $urandom, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
